// File: rtl/control_seq.sv
// Instruction sequencer for the accumulator core: IDLE -> FETCH -> EXEC loop
// with optional wait cycles per phase, ready stalls, jump decode, carry flag and retire counter.
module control_seq #(
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       ir,
    input  logic             aIsZero,
    input  logic             aluCarry,
    input  logic             ready,
    output logic             loadIR,
    output logic             loadPC,
    output logic             loadA,
    output logic             loadB,
    output logic             loadX,
    output logic             storeMem,
    output logic             doOut,
    output logic             provideMem,
    output logic             provideAlu,
    output logic             provideA,
    output logic             provideX,
    output logic             immediate,
    output logic             doSubtract,
    output logic             incPC,
    output logic             flagCarry,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] instrCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } seqState_t;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    seqState_t  curState;
    seqState_t  nextState;
    logic [2:0] waitCnt;

    logic       bit7;
    logic       bit6;
    logic [1:0] source;
    logic [2:0] dest;
    logic       indexed;
    logic       commit;
    logic       advance;
    logic       jump;

    assign bit7    = ir[7];
    assign bit6    = ir[6];
    assign source  = ir[5:4];
    assign dest    = ir[3:1];
    assign indexed = ir[0];

    // The phase may only move on in its last cycle, and only when the bus is ready.
    assign commit  = (waitCnt == WAIT_LAST);
    assign advance = commit & ready;

    // Jump conditions look at the carry latched by an earlier instruction, not the live ALU carry.
    assign jump = (bit6 & aIsZero) | (bit7 & flagCarry) | (bit6 & bit7);

    assign state  = curState;
    assign halted = (curState == HALT);

    // NOTE: every output and nextState gets a default before the case, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        nextState  = curState;
        loadIR     = 1'b0;
        loadPC     = 1'b0;
        loadA      = 1'b0;
        loadB      = 1'b0;
        loadX      = 1'b0;
        storeMem   = 1'b0;
        doOut      = 1'b0;
        provideMem = 1'b0;
        provideAlu = 1'b0;
        provideA   = 1'b0;
        provideX   = 1'b0;
        immediate  = 1'b0;
        doSubtract = 1'b0;
        incPC      = 1'b0;

        case (curState)
            IDLE: begin
                nextState = FETCH;
            end

            FETCH: begin
                provideMem = 1'b1;
                if (advance) begin
                    loadIR    = 1'b1;
                    incPC     = 1'b1;
                    nextState = EXEC;
                end
            end

            EXEC: begin
                immediate  = ~indexed;
                doSubtract = bit6;
                // A halt instruction drives nothing onto the bus.
                if (dest != 3'd7) begin
                    provideMem = (source == 2'd0);
                    provideAlu = (source == 2'd1);
                    provideA   = (source == 2'd2);
                    provideX   = (source == 2'd3);
                end
                if (advance) begin
                    nextState = (dest == 3'd7) ? HALT : FETCH;
                    case (dest)
                        3'd0:    loadIR   = 1'b1;
                        3'd1:    loadPC   = jump;
                        3'd2:    loadA    = 1'b1;
                        3'd3:    loadX    = 1'b1;
                        3'd4:    loadB    = 1'b1;
                        3'd5:    storeMem = 1'b1;
                        3'd6:    doOut    = 1'b1;
                        default: ;
                    endcase
                end
            end

            HALT: begin
                nextState = HALT;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curState   <= IDLE;
            waitCnt    <= 3'd0;
            flagCarry  <= 1'b0;
            instrCount <= '0;
        end else begin
            curState <= nextState;

            if (curState == FETCH || curState == EXEC) begin
                if (!commit) begin
                    waitCnt <= waitCnt + 3'd1;
                end else if (ready) begin
                    waitCnt <= 3'd0;
                end
            end else begin
                waitCnt <= 3'd0;
            end

            if (curState == EXEC && advance) begin
                instrCount <= instrCount + CNT_W'(1);
                if (loadA && provideAlu) begin
                    flagCarry <= aluCarry;
                end
            end
        end
    end

endmodule

// File: tb/tb_control_seq.sv
// Bench for control_seq: cycle vector table on a WAIT_CYCLES=0 core, hand-written
// reset/halt/stall sequences, and a retire scoreboard on a WAIT_CYCLES=2, CNT_W=2 core.
module tb_control_seq;

    localparam logic [13:0] S_LIR = 14'h2000;
    localparam logic [13:0] S_LPC = 14'h1000;
    localparam logic [13:0] S_LA  = 14'h0800;
    localparam logic [13:0] S_LB  = 14'h0400;
    localparam logic [13:0] S_LX  = 14'h0200;
    localparam logic [13:0] S_ST  = 14'h0100;
    localparam logic [13:0] S_OUT = 14'h0080;
    localparam logic [13:0] P_MEM = 14'h0040;
    localparam logic [13:0] P_ALU = 14'h0020;
    localparam logic [13:0] P_A   = 14'h0010;
    localparam logic [13:0] P_X   = 14'h0008;
    localparam logic [13:0] IMM   = 14'h0004;
    localparam logic [13:0] SUB   = 14'h0002;
    localparam logic [13:0] INC   = 14'h0001;
    localparam logic [13:0] F_ALL = P_MEM | S_LIR | INC;

    typedef struct {
        logic [7:0]  ir;
        logic        aIsZero;
        logic        aluCarry;
        logic        ready;
        logic [1:0]  state;
        logic [13:0] strb;
        logic        halted;
        logic        flag;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        int          idx;
        logic [1:0]  state;
        logic [13:0] strb;
        logic        halted;
        logic        flag;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetA, zA, cA, rdyA;
    logic [7:0]  irA;
    wire  [13:0] strA;
    logic        flagA, haltA;
    logic [1:0]  stateA;
    logic [15:0] cntA;

    logic        resetB, zB, cB, rdyB;
    logic [7:0]  irB;
    wire  [13:0] strB;
    logic        flagB, haltB;
    logic [1:0]  stateB;
    logic [1:0]  cntB;

    int checks = 0;
    int errors = 0;

    exp_t       sbA[$];
    logic [1:0] sbB[$];
    vec_t       tbl[29];

    int execCycB  = 0;
    int loadAPulB = 0;

    control_seq #(.WAIT_CYCLES(0), .CNT_W(16)) dutA (
        .clk(clk), .reset(resetA), .ir(irA), .aIsZero(zA), .aluCarry(cA), .ready(rdyA),
        .loadIR(strA[13]), .loadPC(strA[12]), .loadA(strA[11]), .loadB(strA[10]),
        .loadX(strA[9]), .storeMem(strA[8]), .doOut(strA[7]), .provideMem(strA[6]),
        .provideAlu(strA[5]), .provideA(strA[4]), .provideX(strA[3]), .immediate(strA[2]),
        .doSubtract(strA[1]), .incPC(strA[0]), .flagCarry(flagA), .halted(haltA),
        .state(stateA), .instrCount(cntA)
    );

    control_seq #(.WAIT_CYCLES(2), .CNT_W(2)) dutB (
        .clk(clk), .reset(resetB), .ir(irB), .aIsZero(zB), .aluCarry(cB), .ready(rdyB),
        .loadIR(strB[13]), .loadPC(strB[12]), .loadA(strB[11]), .loadB(strB[10]),
        .loadX(strB[9]), .storeMem(strB[8]), .doOut(strB[7]), .provideMem(strB[6]),
        .provideAlu(strB[5]), .provideA(strB[4]), .provideX(strB[3]), .immediate(strB[2]),
        .doSubtract(strB[1]), .incPC(strB[0]), .flagCarry(flagB), .halted(haltB),
        .state(stateB), .instrCount(cntB)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expectA(input string name, input logic [1:0] st, input logic [13:0] s,
                           input logic h, input logic f, input logic [15:0] cnt);
        check({name, " state/halted/flag"}, {28'd0, stateA, haltA, flagA}, {28'd0, st, h, f});
        check({name, " strobes"}, {18'd0, strA}, {18'd0, s});
        check({name, " count"}, {16'd0, cntA}, {16'd0, cnt});
    endtask

    function automatic vec_t mk(input logic [7:0] ir, input logic z, input logic c,
                                input logic rdy, input logic [1:0] st, input logic [13:0] s,
                                input logic h, input logic f, input logic [15:0] cnt);
        vec_t v;
        v.ir = ir; v.aIsZero = z; v.aluCarry = c; v.ready = rdy;
        v.state = st; v.strb = s; v.halted = h; v.flag = f; v.cnt = cnt;
        return v;
    endfunction

    task automatic applyVec(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        irA = v.ir; zA = v.aIsZero; cA = v.aluCarry; rdyA = v.ready;
        sbA.push_back('{idx, v.state, v.strb, v.halted, v.flag, v.cnt});
        #2;
        e = sbA.pop_front();
        expectA($sformatf("vec%0d", e.idx), e.state, e.strb, e.halted, e.flag, e.cnt);
    endtask

    // Retire monitor for core B: an EXEC->non-EXEC transition means one instruction retired.
    initial begin
        logic [1:0] prevB;
        logic [1:0] expCnt;
        prevB = 2'd0;
        forever begin
            @(negedge clk);
            if (!resetB) begin
                if (stateB == 2'd2) execCycB++;
                if (strB[11]) loadAPulB++;
                if (prevB == 2'd2 && stateB != 2'd2) begin
                    if (sbB.size() == 0) begin
                        check("B unexpected retire", 32'd1, 32'd0);
                    end else begin
                        expCnt = sbB.pop_front();
                        check("B retire count", {30'd0, cntB}, {30'd0, expCnt});
                    end
                end
            end
            prevB = stateB;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int fetchCyc, pulses, incPulses, pulseAt, k;

        resetA = 1'b1; irA = 8'h00; zA = 1'b0; cA = 1'b0; rdyA = 1'b0;
        resetB = 1'b1; irB = 8'h14; zB = 1'b0; cB = 1'b0; rdyB = 1'b1;

        tbl[0]  = mk(8'h14, 0, 0, 1, 2'd0, 14'd0,              0, 0, 16'd0);
        tbl[1]  = mk(8'h14, 0, 0, 1, 2'd1, F_ALL,              0, 0, 16'd0);
        tbl[2]  = mk(8'h14, 0, 1, 1, 2'd2, P_ALU | S_LA | IMM, 0, 0, 16'd0);
        tbl[3]  = mk(8'h82, 0, 0, 1, 2'd1, F_ALL,              0, 1, 16'd1);
        tbl[4]  = mk(8'h82, 0, 0, 1, 2'd2, P_MEM | S_LPC | IMM, 0, 1, 16'd1);
        tbl[5]  = mk(8'h14, 0, 0, 1, 2'd1, F_ALL,              0, 1, 16'd2);
        tbl[6]  = mk(8'h14, 0, 0, 1, 2'd2, P_ALU | S_LA | IMM, 0, 1, 16'd2);
        tbl[7]  = mk(8'h82, 1, 0, 1, 2'd1, F_ALL,              0, 0, 16'd3);
        tbl[8]  = mk(8'h82, 1, 0, 1, 2'd2, P_MEM | IMM,        0, 0, 16'd3);
        tbl[9]  = mk(8'hC2, 0, 0, 1, 2'd1, F_ALL,              0, 0, 16'd4);
        tbl[10] = mk(8'hC2, 0, 0, 1, 2'd2, P_MEM | S_LPC | IMM | SUB, 0, 0, 16'd4);
        tbl[11] = mk(8'h43, 1, 0, 1, 2'd1, F_ALL,              0, 0, 16'd5);
        tbl[12] = mk(8'h43, 1, 0, 1, 2'd2, P_MEM | S_LPC | SUB, 0, 0, 16'd5);
        tbl[13] = mk(8'h2A, 0, 1, 0, 2'd1, P_MEM,              0, 0, 16'd6);
        tbl[14] = mk(8'h2A, 0, 1, 1, 2'd1, F_ALL,              0, 0, 16'd6);
        tbl[15] = mk(8'h2A, 0, 1, 0, 2'd2, P_A | IMM,          0, 0, 16'd6);
        tbl[16] = mk(8'h2A, 0, 1, 1, 2'd2, P_A | S_ST | IMM,   0, 0, 16'd6);
        tbl[17] = mk(8'h37, 0, 1, 1, 2'd1, F_ALL,              0, 0, 16'd7);
        tbl[18] = mk(8'h37, 0, 1, 1, 2'd2, P_X | S_LX,         0, 0, 16'd7);
        tbl[19] = mk(8'h19, 0, 1, 1, 2'd1, F_ALL,              0, 0, 16'd8);
        tbl[20] = mk(8'h19, 0, 1, 1, 2'd2, P_ALU | S_LB,       0, 0, 16'd8);
        tbl[21] = mk(8'h0C, 0, 0, 1, 2'd1, F_ALL,              0, 0, 16'd9);
        tbl[22] = mk(8'h0C, 0, 0, 1, 2'd2, P_MEM | S_OUT | IMM, 0, 0, 16'd9);
        tbl[23] = mk(8'h31, 0, 0, 1, 2'd1, F_ALL,              0, 0, 16'd10);
        tbl[24] = mk(8'h31, 0, 0, 1, 2'd2, P_X | S_LIR,        0, 0, 16'd10);
        tbl[25] = mk(8'h0F, 0, 0, 1, 2'd1, F_ALL,              0, 0, 16'd11);
        tbl[26] = mk(8'h0F, 1, 1, 1, 2'd2, 14'd0,              0, 0, 16'd11);
        tbl[27] = mk(8'hC2, 0, 0, 0, 2'd3, 14'd0,              1, 0, 16'd12);
        tbl[28] = mk(8'h14, 1, 1, 1, 2'd3, 14'd0,              1, 0, 16'd12);

        #12;
        expectA("in reset", 2'd0, 14'd0, 0, 0, 16'd0);
        check("B in reset state", {30'd0, stateB}, 32'd0);

        // Main vector table on core A.
        @(posedge clk); #1 resetA = 1'b0;
        for (int i = 0; i < 29; i++) applyVec(tbl[i], i);

        // Asynchronous reset while halted, without a clock edge.
        @(negedge clk); #1 resetA = 1'b1;
        #1 expectA("async reset in HALT", 2'd0, 14'd0, 0, 0, 16'd0);

        // Halt instruction 8'h0E, then HALT must ignore ready and ir.
        @(posedge clk); #1 resetA = 1'b0; irA = 8'h0E; rdyA = 1'b1; zA = 1'b0; cA = 1'b0;
        @(negedge clk); #2 expectA("0E idle", 2'd0, 14'd0, 0, 0, 16'd0);
        @(negedge clk); #2 expectA("0E fetch", 2'd1, F_ALL, 0, 0, 16'd0);
        @(negedge clk); #2
        check("0E exec state", {30'd0, stateA}, 32'd2);
        check("0E exec no strobes/selects", {18'd0, strA & ~(IMM | SUB)}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rdyA = 1'($urandom_range(0, 1));
            irA  = 8'($urandom_range(0, 255));
            #2 expectA($sformatf("0E halt%0d", i), 2'd3, 14'd0, 1, 0, 16'd1);
        end
        #1 resetA = 1'b1;
        #1 expectA("reset out of 0E halt", 2'd0, 14'd0, 0, 0, 16'd0);

        // Reset during an EXEC ready stall must discard the pending commit.
        @(posedge clk); #1 resetA = 1'b0; irA = 8'h14; cA = 1'b1; rdyA = 1'b1;
        @(negedge clk); #2 expectA("stall idle", 2'd0, 14'd0, 0, 0, 16'd0);
        @(negedge clk); #2 expectA("stall fetch", 2'd1, F_ALL, 0, 0, 16'd0);
        @(negedge clk); #2 expectA("stall exec1", 2'd2, P_ALU | S_LA | IMM, 0, 0, 16'd0);
        @(negedge clk); #2 expectA("stall fetch2", 2'd1, F_ALL, 0, 1, 16'd1);
        @(negedge clk); rdyA = 1'b0;
        #2 expectA("stall exec2 held", 2'd2, P_ALU | IMM, 0, 1, 16'd1);
        #1 resetA = 1'b1;
        #1 expectA("reset in stall", 2'd0, 14'd0, 0, 0, 16'd0);
        rdyA = 1'b1;
        @(posedge clk); #1 resetA = 1'b0;
        @(negedge clk); #2 expectA("post-stall idle", 2'd0, 14'd0, 0, 0, 16'd0);
        @(negedge clk); #2 expectA("post-stall fetch", 2'd1, F_ALL, 0, 0, 16'd0);

        // Core B: wait cycles, FETCH stall length, counter wrap.
        @(posedge clk); #1 resetB = 1'b0; rdyB = 1'b0;
        sbB.push_back(2'd1);
        @(negedge clk); #2 check("B idle", {30'd0, stateB}, 32'd0);
        fetchCyc = 0; pulses = 0; incPulses = 0; pulseAt = -1; k = 0;
        @(negedge clk);
        while (k < 20) begin
            rdyB = (k >= 5);
            #2;
            if (stateB != 2'd1) break;
            fetchCyc++;
            if (strB[13]) begin pulses++; pulseAt = k; end
            if (strB[0]) incPulses++;
            k++;
            @(negedge clk);
        end
        check("B fetch cycles", fetchCyc, 32'd6);
        check("B loadIR pulses", pulses, 32'd1);
        check("B incPC pulses", incPulses, 32'd1);
        check("B loadIR cycle", pulseAt, 32'd5);

        rdyB = 1'b1;
        for (int i = 1; i < 5; i++) begin
            k = 0;
            while (stateB != 2'd1 && k < 30) begin @(negedge clk); #2 k++; end
            check($sformatf("B reach fetch %0d", i), {31'd0, k < 30}, 32'd1);
            sbB.push_back(2'((i + 1) % 4));
            k = 0;
            while (stateB == 2'd1 && k < 30) begin @(negedge clk); #2 k++; end
        end
        k = 0;
        while (sbB.size() != 0 && k < 40) begin @(negedge clk); #2 k++; end
        resetB = 1'b1;
        check("B all retired", sbB.size(), 32'd0);
        check("B exec cycles", execCycB, 32'd15);
        check("B loadA pulses", loadAPulB, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
